handshake_rx_fifo: RTL and testbench

HANDSHAKE_RX_FIFO -- requirements
Module: handshake_rx_fifo

---
 rtl/handshake_rx_fifo_pkg.sv | 12 +
 rtl/handshake_rx_fifo_store.sv | 51 +++++
 rtl/handshake_rx_fifo.sv | 71 +++++++
 tb/tb_handshake_rx_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/handshake_rx_fifo_pkg.sv
// Shared types and default sizing for the four-phase receive FIFO.
package handshake_rx_fifo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/handshake_rx_fifo_store.sv
// rx_fifo_store: circular word buffer with show-ahead head and occupancy count.
module rx_fifo_store
  import handshake_rx_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard here too so the store can never over- or underflow on its own.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/handshake_rx_fifo.sv
// Four-phase receive handshake feeding a show-ahead FIFO; backpressure by withholding ack.
//   state   | meaning
//   RX_IDLE | waiting for send with room in the FIFO
//   RX_ACK  | word captured, ack high until send drops
module handshake_rx_fifo
  import handshake_rx_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send,
  input  logic [WIDTH-1:0]           data,
  output logic                       ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  rx_state_t state;
  rx_state_t state_next;
  logic      push;
  logic      pop;
  logic      full;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_ready && out_valid;
  // ack decodes the state register only, so send never reaches it combinationally.
  assign ack       = (state == RX_ACK);

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (send && !full) begin
          state_next = RX_ACK;
          push       = 1'b1;
        end
      end
      RX_ACK: begin
        if (!send) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  rx_fifo_store #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data),
    .pop      (pop),
    .head     (out_data),
    .count    (count)
  );

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_handshake_rx_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             send = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  handshake_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue plus one "acknowledged, waiting for send to drop" flag.
  logic [WIDTH-1:0] mq[$];
  bit               m_acked = 0;
  bit               m_live  = 0;
  int               max_cnt = 0;

  always @(posedge clk) begin
    bit accept, take;
    if (rst) begin
      mq.delete();
      m_acked = 0;
      m_live  = 1;
    end else if (m_live) begin
      accept = !m_acked && send && (mq.size() < DEPTH);
      take   = out_ready && (mq.size() > 0);
      if (take) void'(mq.pop_front());
      if (accept) mq.push_back(data);
      if (accept) m_acked = 1;
      else if (m_acked && !send) m_acked = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("ack", int'(ack), int'(m_acked));
      chk("count", int'(count), mq.size());
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", int'(out_data), int'(mq[0]));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  // Called at a negedge: drive inputs, return at the next negedge.
  task automatic cyc(input bit s, input int d, input bit r);
    send = s; data = WIDTH'(d); out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; send = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic xfer(input int d, input bit r);
    int n;
    n = 0;
    cyc(1, d, r);
    while (!ack && n < 50) begin cyc(1, d, r); n++; end
    if (!ack) chk("xfer_ack_timeout", 0, 1);
    n = 0;
    cyc(0, d, r);
    while (ack && n < 50) begin cyc(0, d, r); n++; end
    if (ack) chk("xfer_release_timeout", 0, 1);
  endtask

  initial begin
    @(negedge clk);
    // Single transfer after reset.
    do_reset();
    cyc(1, 12, 0);
    chk("t1_ack", int'(ack), 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 12);
    chk("t1_count", int'(count), 1);
    cyc(0, 12, 0);
    chk("t1_ack_drop", int'(ack), 0);

    // Fill, backpressure, single pop frees one slot.
    do_reset();
    for (int i = 1; i <= 4; i++) xfer(i, 0);
    chk("t2_full", int'(count), 4);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5, 0);
      chk("t2_bp_ack", int'(ack), 0);
      chk("t2_bp_count", int'(count), 4);
    end
    cyc(1, 5, 1);
    chk("t2_pop_noack", int'(ack), 0);
    chk("t2_pop_count", int'(count), 3);
    cyc(1, 5, 0);
    chk("t2_accept_ack", int'(ack), 1);
    chk("t2_accept_count", int'(count), 4);
    cyc(0, 5, 0);
    for (int v = 2; v <= 5; v++) begin
      chk("t2_drain", int'(out_data), v);
      cyc(0, 0, 1);
    end
    chk("t2_empty", int'(out_valid), 0);

    // Streaming with the consumer always ready; pointers wrap twice.
    do_reset();
    max_cnt = 0;
    for (int i = 0; i < 10; i++) xfer(i, 1);
    chk("t3_max_count", max_cnt, 1);
    chk("t3_empty", int'(count), 0);

    // Simultaneous push and pop at count 2.
    do_reset();
    xfer(7, 0);
    xfer(8, 0);
    chk("t4_pre", int'(count), 2);
    cyc(1, 9, 1);
    chk("t4_count", int'(count), 2);
    chk("t4_head", int'(out_data), 8);
    cyc(0, 9, 0);
    chk("t4_head2", int'(out_data), 8);
    cyc(0, 0, 1);
    chk("t4_tail", int'(out_data), 9);
    cyc(0, 0, 1);

    // Reset mid-handshake with send still high.
    do_reset();
    xfer(1, 0);
    xfer(2, 0);
    cyc(1, 3, 0);
    chk("t5_ack", int'(ack), 1);
    chk("t5_count", int'(count), 3);
    rst = 1'b1;
    cyc(1, 3, 0);
    rst = 1'b0;
    chk("t5_rst_ack", int'(ack), 0);
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_valid", int'(out_valid), 0);
    cyc(1, 3, 0);
    chk("t5_reaccept_ack", int'(ack), 1);
    chk("t5_reaccept_count", int'(count), 1);
    cyc(0, 3, 0);

    // Long send hold writes exactly one word.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 6, 0);
    chk("t6_count", int'(count), 1);
    cyc(0, 6, 0);
    chk("t6_count_after", int'(count), 1);

    // Random traffic, occasional reset; model comparison runs every cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
